// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM stage register: payload+valid with stall/bubble/flush handling, multi-cycle
// loopback channel back to EX, and saturating HOLD/BUBBLE cycle counters.
module ex_mem_pipe_reg #(
  parameter int                   PAYLOAD_W       = 160,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD     = {PAYLOAD_W{1'b0}},
  parameter int                   LOOP_W          = 66,
  parameter int                   STALL_W         = 6,
  parameter int                   STAGE           = 3,
  parameter bit                   CLEAR_ON_BUBBLE = 1'b1,
  parameter int                   PERF_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [STALL_W-1:0]   stall,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [LOOP_W-1:0]    loop_i,
  output logic [LOOP_W-1:0]    loop_o,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [PERF_W-1:0]    hold_cnt,
  output logic [PERF_W-1:0]    bubble_cnt,
  input  logic                 perf_clr
);

  logic up_stop;
  logic down_stop;
  logic do_bubble;
  logic do_hold;

  assign up_stop = stall[STAGE];

  // The last stage has nothing downstream, so a stall there always bubbles.
  generate
    if (STAGE + 1 < STALL_W) begin : g_down
      assign down_stop = stall[STAGE+1];
    end else begin : g_last
      assign down_stop = 1'b0;
    end
  endgenerate

  assign do_bubble = !flush && up_stop && !down_stop;
  assign do_hold   = !flush && up_stop && down_stop;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid   <= 1'b0;
      out_payload <= NOP_PAYLOAD;
      loop_o      <= '0;
    end else if (do_bubble) begin
      out_valid <= 1'b0;
      loop_o    <= loop_i;
      if (CLEAR_ON_BUBBLE) begin
        out_payload <= NOP_PAYLOAD;
      end
    end else if (!up_stop) begin
      out_valid   <= in_valid;
      out_payload <= in_payload;
      loop_o      <= '0;
    end else begin
      loop_o <= loop_i;
    end
  end

  // Counters saturate; perf_clr beats a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || perf_clr) begin
      hold_cnt   <= '0;
      bubble_cnt <= '0;
    end else begin
      if (do_hold && hold_cnt != '1) begin
        hold_cnt <= hold_cnt + PERF_W'(1);
      end
      if (do_bubble && bubble_cnt != '1) begin
        bubble_cnt <= bubble_cnt + PERF_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench: default instance plus variants for payload-keeping bubbles,
// last-stage placement and narrow saturating counters, all fed the same inputs.
module tb_ex_mem_pipe_reg;

  localparam int PW = 160;
  localparam int LW = 66;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic          flush;
  logic          in_valid;
  logic [PW-1:0] in_payload;
  logic [LW-1:0] loop_i;
  logic          perf_clr;

  logic [LW-1:0] loop_a, loop_b, loop_c, loop_d;
  logic          vld_a, vld_b, vld_c, vld_d;
  logic [PW-1:0] pay_a, pay_b, pay_c, pay_d;
  logic [15:0]   hold_a, bub_a, hold_b, bub_b, hold_c, bub_c;
  logic [3:0]    hold_d, bub_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_reg u_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_payload(in_payload), .loop_i(loop_i), .loop_o(loop_a), .out_valid(vld_a),
    .out_payload(pay_a), .hold_cnt(hold_a), .bubble_cnt(bub_a), .perf_clr(perf_clr));

  ex_mem_pipe_reg #(.CLEAR_ON_BUBBLE(1'b0)) u_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_payload(in_payload), .loop_i(loop_i), .loop_o(loop_b), .out_valid(vld_b),
    .out_payload(pay_b), .hold_cnt(hold_b), .bubble_cnt(bub_b), .perf_clr(perf_clr));

  ex_mem_pipe_reg #(.STAGE(5)) u_c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_payload(in_payload), .loop_i(loop_i), .loop_o(loop_c), .out_valid(vld_c),
    .out_payload(pay_c), .hold_cnt(hold_c), .bubble_cnt(bub_c), .perf_clr(perf_clr));

  ex_mem_pipe_reg #(.PERF_W(4)) u_d (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_payload(in_payload), .loop_i(loop_i), .loop_o(loop_d), .out_valid(vld_d),
    .out_payload(pay_d), .hold_cnt(hold_d), .bubble_cnt(bub_d), .perf_clr(perf_clr));

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [PW-1:0] P_ABCD = 160'h0123_4567_89AB_CDEF_0000_1111_2222_3333_4444_ABCD;
  localparam logic [LW-1:0] LOOPV  = 66'h1_2345_6789_ABCD_EF01;

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b1;
    in_payload = P_ABCD; loop_i = '0; perf_clr = 1'b0;

    // Reset held two cycles
    tick();
    check("rst1_vld", vld_a, 0);
    check("rst1_pay", pay_a, 0);
    tick();
    check("rst2_vld", vld_a, 0);
    check("rst2_pay", pay_a, 0);
    check("rst_loop", loop_a, 0);
    check("rst_hold", hold_a, 0);
    check("rst_bub", bub_a, 0);

    // Advance after release
    rst = 1'b0;
    tick();
    check("adv_vld", vld_a, 1);
    check("adv_pay", pay_a, P_ABCD);
    check("adv_loop", loop_a, 0);

    // Bubble: loop_o tracks loop_i with one cycle lag
    stall = 6'b001111;
    for (int i = 0; i < 3; i++) begin
      loop_i = LOOPV + LW'(i);
      tick();
      check("bub_vld", vld_a, 0);
      check("bub_pay", pay_a, 0);
      check("bub_loop", loop_a, LOOPV + LW'(i));
    end
    check("bub_cnt3", bub_a, 3);
    check("bub_hold0", hold_a, 0);

    stall = '0; in_valid = 1'b0;
    tick();
    check("rel_loop", loop_a, 0);
    check("rel_vld", vld_a, 0);

    // Hold: payload and valid frozen
    in_valid = 1'b1; in_payload = 160'h55;
    tick();
    check("ld55", pay_a, 160'h55);
    stall = 6'b011111; in_payload = 160'h99; loop_i = 66'h2_0000_0000_0000_00AA;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_pay", pay_a, 160'h55);
      check("hold_vld", vld_a, 1);
    end
    check("hold_cnt4", hold_a, 4);
    check("hold_bub", bub_a, 3);
    check("hold_loop", loop_a, 66'h2_0000_0000_0000_00AA);

    // Flush beats bubble
    stall = 6'b001111; flush = 1'b1; loop_i = LOOPV;
    tick();
    check("fl_vld", vld_a, 0);
    check("fl_loop", loop_a, 0);
    check("fl_pay", pay_a, 0);
    check("fl_bub", bub_a, 3);
    flush = 1'b0;

    // Payload-keeping bubble variant
    stall = '0; in_payload = 160'h77; in_valid = 1'b1;
    tick();
    stall = 6'b001111;
    tick();
    check("keep_pay", pay_b, 160'h77);
    check("keep_vld", vld_b, 0);
    check("clr_pay", pay_a, 0);

    // Last-stage instance: stall[5] has no downstream, so it bubbles
    stall = '0; in_payload = 160'h88;
    tick();
    check("last_pre", vld_c, 1);
    stall = 6'b100000;
    tick();
    check("last_vld", vld_c, 0);
    check("last_pay", pay_c, 0);
    check("last_bub", bub_c, 1);
    check("last_hold", hold_c, 0);
    check("a_adv", pay_a, 160'h88);

    // 4-bit counter saturation (already at 4 bubbles)
    check("d_bub4", bub_d, 4);
    stall = 6'b001111;
    for (int i = 0; i < 20; i++) tick();
    check("sat_bub", bub_d, 15);
    check("sat_hold", hold_d, 4);
    perf_clr = 1'b1;
    tick();
    check("clr_bub", bub_d, 0);
    check("clr_hold", hold_d, 0);
    perf_clr = 1'b0;
    tick();
    check("post_clr", bub_d, 1);

    // Reset mid multi-cycle op
    stall = 6'b011111; loop_i = LOOPV;
    tick();
    check("mid_loop", loop_a, LOOPV);
    rst = 1'b1;
    tick();
    check("mrst_loop", loop_a, 0);
    check("mrst_vld", vld_a, 0);
    check("mrst_hold", hold_a, 0);
    check("mrst_bub", bub_a, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
